// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counting engine.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

  localparam bcd_t TENTHS_MAX   = 4'd9;
  localparam bcd_t SEC_ONES_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_ONES_MAX = 4'd9;
  localparam bcd_t BCD_ZERO     = 4'd0;

endpackage

// File: rtl/tick_edge_detect.sv
// Three-flop synchroniser with rising-edge detect; one-cycle tick per rising edge of level_in.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic tick_out
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= level_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s1 is metastability settling only; the edge is taken between s2 and s3
  assign tick_out = s2_q & ~s3_q;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch engine: start/pause/clear FSM plus a BCD MM:SS.t counter advanced by 10 Hz ticks.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned MINUTES_MAX = 59
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tenHzClk,
  input  logic               start_stop,
  input  logic               clear,
  output logic               running,
  output logic [DIGIT_W-1:0] tenths,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic               wrap
);

  localparam bcd_t MIN_TENS_LIM = bcd_t'(MINUTES_MAX / 10);
  localparam bcd_t MIN_ONES_LIM = bcd_t'(MINUTES_MAX % 10);

  logic   tick;
  state_e state_q,    state_d;
  bcd_t   tenths_q,   tenths_d;
  bcd_t   sec_ones_q, sec_ones_d;
  bcd_t   sec_tens_q, sec_tens_d;
  bcd_t   min_ones_q, min_ones_d;
  bcd_t   min_tens_q, min_tens_d;
  logic   wrap_q,     wrap_d;
  logic   running_q;

  tick_edge_detect u_tick (
    .clk      (clk),
    .rst      (rst),
    .level_in (tenHzClk),
    .tick_out (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tenths_q   <= BCD_ZERO;
      sec_ones_q <= BCD_ZERO;
      sec_tens_q <= BCD_ZERO;
      min_ones_q <= BCD_ZERO;
      min_tens_q <= BCD_ZERO;
      wrap_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tenths_q   <= tenths_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      wrap_q     <= wrap_d;
      running_q  <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d    = state_q;
    tenths_d   = tenths_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;

    if (clear) begin
      // clear overrides both start_stop and a coincident tick
      state_d    = IDLE;
      tenths_d   = BCD_ZERO;
      sec_ones_d = BCD_ZERO;
      sec_tens_d = BCD_ZERO;
      min_ones_d = BCD_ZERO;
      min_tens_d = BCD_ZERO;
    end else begin
      if ((state_q == RUN) && tick) begin
        if (tenths_q != TENTHS_MAX) begin
          tenths_d = tenths_q + 4'd1;
        end else begin
          tenths_d = BCD_ZERO;
          if (sec_ones_q != SEC_ONES_MAX) begin
            sec_ones_d = sec_ones_q + 4'd1;
          end else begin
            sec_ones_d = BCD_ZERO;
            if (sec_tens_q != SEC_TENS_MAX) begin
              sec_tens_d = sec_tens_q + 4'd1;
            end else begin
              sec_tens_d = BCD_ZERO;
              if ((min_tens_q == MIN_TENS_LIM) && (min_ones_q == MIN_ONES_LIM)) begin
                min_ones_d = BCD_ZERO;
                min_tens_d = BCD_ZERO;
                wrap_d     = 1'b1;
              end else if (min_ones_q == MIN_ONES_MAX) begin
                min_ones_d = BCD_ZERO;
                min_tens_d = min_tens_q + 4'd1;
              end else begin
                min_ones_d = min_ones_q + 4'd1;
              end
            end
          end
        end
      end

      // counting above uses the current state, so a tick with start_stop in RUN still counts
      case (state_q)
        IDLE:    if (start_stop) state_d = RUN;
        RUN:     if (start_stop) state_d = PAUSED;
        PAUSED:  if (start_stop) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  assign running  = running_q;
  assign tenths   = tenths_q;
  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with MINUTES_MAX=12 so the rollover is reachable quickly.
module tb_stopwatch_core;

  logic       clk;
  logic       rst;
  logic       tenHzClk;
  logic       start_stop;
  logic       clear;
  logic       running;
  logic [3:0] tenths;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       wrap;
  logic [19:0] disp;

  int total  = 0;
  int passed = 0;

  stopwatch_core #(.MINUTES_MAX(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .tenHzClk   (tenHzClk),
    .start_stop (start_stop),
    .clear      (clear),
    .running    (running),
    .tenths     (tenths),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .wrap       (wrap)
  );

  assign disp = {min_tens, min_ones, sec_tens, sec_ones, tenths};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // one square-wave period: 2 clk high, 2 clk low; the count settles before return
  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      tenHzClk = 1'b1;
      repeat (2) @(negedge clk);
      tenHzClk = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  // one period with start_stop/clear presented on the edge where the tick is live
  task automatic edge_with(input logic ss, input logic clr, output logic wrap_seen);
    tenHzClk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start_stop = ss;
    clear      = clr;
    tenHzClk   = 1'b0;
    @(negedge clk);
    wrap_seen  = wrap;
    start_stop = 1'b0;
    clear      = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    logic w;
    rst = 1'b0; tenHzClk = 1'b0; start_stop = 1'b0; clear = 1'b0;

    // reset with the wave toggling, then release while the wave is high
    repeat (3) begin
      repeat (2) @(negedge clk);
      tenHzClk = ~tenHzClk;
    end
    tenHzClk = 1'b1;
    @(negedge clk);
    check("rst_disp", disp, 20'h00000);
    check("rst_running", 20'(running), 20'h0);
    check("rst_wrap", 20'(wrap), 20'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    tenHzClk = 1'b0;
    repeat (2) @(negedge clk);
    edges(5);
    check("idle_disp", disp, 20'h00000);
    check("idle_running", 20'(running), 20'h0);

    // start, then exact 2-edge latency of the first tick
    pulse_ss();
    check("start_running", 20'(running), 20'h1);
    tenHzClk = 1'b1;
    @(negedge clk);
    check("lat_k0", disp, 20'h00000);
    @(negedge clk);
    check("lat_k1", disp, 20'h00000);
    tenHzClk = 1'b0;
    @(negedge clk);
    check("lat_k2", disp, 20'h00001);
    @(negedge clk);
    edges(124);
    check("run_12_5", disp, 20'h00125);
    check("run_12_5_running", 20'(running), 20'h1);

    // pause holds the display, resume continues from it
    pulse_clear();
    check("clear_disp", disp, 20'h00000);
    check("clear_running", 20'(running), 20'h0);
    pulse_ss();
    edges(30);
    check("run_3_0", disp, 20'h00030);
    pulse_ss();
    check("pause_running", 20'(running), 20'h0);
    edges(10);
    check("pause_hold_a", disp, 20'h00030);
    edges(10);
    check("pause_hold_b", disp, 20'h00030);
    pulse_ss();
    edges(7);
    check("resume_3_7", disp, 20'h00037);
    check("resume_running", 20'(running), 20'h1);

    // clear coincident with the tick at 00:09.9
    pulse_clear();
    pulse_ss();
    edges(99);
    check("run_9_9", disp, 20'h00099);
    edge_with(1'b0, 1'b1, w);
    check("clr_tick_wrap", 20'(w), 20'h0);
    check("clr_tick_disp", disp, 20'h00000);
    check("clr_tick_running", 20'(running), 20'h0);
    edges(5);
    check("clr_tick_after", disp, 20'h00000);

    // asynchronous reset mid-count at 01:23.4
    pulse_ss();
    edges(834);
    check("run_1_23_4", disp, 20'h01234);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_disp", disp, 20'h00000);
    check("async_rst_running", 20'(running), 20'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    edges(5);
    check("post_rst_idle", disp, 20'h00000);
    pulse_ss();
    edges(3);
    check("post_rst_run", disp, 20'h00003);

    // rollover at 12:59.9
    pulse_clear();
    pulse_ss();
    edges(7798);
    check("run_12_59_8", disp, 20'h12598);
    edges(1);
    check("run_12_59_9", disp, 20'h12599);
    check("pre_wrap_wrap", 20'(wrap), 20'h0);
    edge_with(1'b0, 1'b0, w);
    check("wrap_pulse", 20'(w), 20'h1);
    check("wrap_disp", disp, 20'h00000);
    check("wrap_one_cycle", 20'(wrap), 20'h0);
    check("wrap_running", 20'(running), 20'h1);
    edges(1);
    check("after_wrap", disp, 20'h00001);

    // start_stop with tick: counted in RUN, discarded in PAUSED
    edge_with(1'b1, 1'b0, w);
    check("ss_tick_run_disp", disp, 20'h00002);
    check("ss_tick_run_state", 20'(running), 20'h0);
    edge_with(1'b1, 1'b0, w);
    check("ss_tick_pause_disp", disp, 20'h00002);
    check("ss_tick_pause_state", 20'(running), 20'h1);
    edges(2);
    check("final_disp", disp, 20'h00004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Counting engine of the stopwatch: it consumes the 10 Hz square wave produced by the clock-enable divider. It synchronises and rising-edge-detects that wave into one-cycle ticks, and runs a start/pause/clear state machine. It also maintains a BCD time count MM:SS.t for the display multiplexer. It sits between the divider and the seven-segment driver, all in the single `clk` domain.

## Interface
- `MINUTES_MAX`, default 59: highest minute value before wrap; legal range 1..99.
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset, asynchronous, active-low.
- `tenHzClk`  in  1  10 Hz square wave from the divider; one rising edge per 100 ms.
- `start_stop`  in  1  one-cycle pulse, debounced upstream; toggles run/pause.
- `clear`  in  1  one-cycle pulse; zeroes the count and returns to IDLE.
- `running`  out  1  high while in RUN.
- `tenths`  out  4  BCD 0..9.
- `sec_ones`  out  4  BCD 0..9.
- `sec_tens`  out  4  BCD 0..5.
- `min_ones`  out  4  BCD 0..9.
- `min_tens`  out  4  BCD 0..9, bounded by `MINUTES_MAX`.
- `wrap`  out  1  one-cycle pulse when the count rolls over to 00:00.0.

## Operation
- Reset (`rst` low): state IDLE, all digits 0, `running` 0, `wrap` 0, synchroniser flops s1/s2/s3 all 0.
- Tick path: `tenHzClk` → s1 → s2 → s3. Define `tick = s2 & ~s3`. Exactly one tick per rising edge of `tenHzClk`; falling edges produce nothing.
- FSM states: IDLE, RUN, PAUSED.
  - IDLE + start_stop → RUN.
  - RUN + start_stop → PAUSED.
  - PAUSED + start_stop → RUN.
  - Any state + clear → IDLE, digits zeroed.
- Counting: only in RUN and only on `tick`. Digit cascade:
  - `tenths` 9→0 carries into `sec_ones`.
  - `sec_ones` 9→0 carries into `sec_tens`.
  - `sec_tens` 5→0 carries into `min_ones`.
  - `min_ones` 9→0 carries into `min_tens`.
- Wrap: a tick at `MINUTES_MAX`:59.9 → 00:00.0. `wrap` pulses for one cycle and the state stays RUN.
- Display holds: PAUSED holds the digits; IDLE shows 00:00.0.
- Simultaneous events:
  - clear + start_stop: clear wins; state IDLE; start_stop discarded.
  - clear + tick: clear wins; digits 0; no `wrap`.
  - start_stop + tick while in RUN: the tick is counted, then PAUSED.
  - start_stop + tick while in IDLE/PAUSED: the tick is not counted; state becomes RUN.
- Ticks in IDLE/PAUSED are discarded, never queued.
- Reset released while `tenHzClk` is high: a tick fires while in IDLE and is discarded.

## Timing
- `tenHzClk` first sampled high at clk edge k: s2 is high after edge k+1, `tick` is high in the cycle k+1..k+2, and the digits update at edge k+2.
- `running` updates at the edge that samples `start_stop`/`clear`; zero-cycle combinational paths are forbidden.
- `wrap` is registered and high for exactly the one cycle following the rollover edge.
- All outputs are registered; no combinational input-to-output path.
- `tick` spacing is ≥ 2 cycles by construction. Tick-to-tick spacing is 10,000,000 cycles at 100 MHz; the bench may drive faster square waves (period ≥ 4 clk).

## Structure
- Package `stopwatch_pkg`:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2).
  - Digit limit constants (TENTHS_MAX=9, SEC_ONES_MAX=9, SEC_TENS_MAX=5).
  - BCD digit type width (4).
- Sub-module `tick_edge_detect`: the 3-flop synchroniser plus rising-edge detector (ports `clk`, `rst`, `level_in`, `tick_out`). It is reusable for the button path.
- The FSM and BCD cascade live in `stopwatch_core`. `MINUTES_MAX` is split into tens/ones limits at elaboration.

## Test plan
- Reset held low with `tenHzClk` toggling → all digits 0, `running`=0, `wrap`=0. After release with no `start_stop` → digits stay 0.
- start_stop, then 125 rising edges of `tenHzClk` → display 00:12.5, `running`=1. Each digit change lands exactly 2 clk edges after the first high sample.
- RUN to 00:03.0, start_stop, 20 edges, start_stop, 7 edges → 00:03.7. PAUSED shows 00:03.0 throughout the pause.
- Preload-by-run to 59:59.8 (`MINUTES_MAX`=59), 2 edges → 00:00.0 with `wrap` high exactly one cycle, then 00:00.1, `running`=1.
- clear asserted in the same cycle as `tick` at 00:09.9 → 00:00.0, state IDLE, no `wrap`. Further edges leave the display at 00:00.0.
- `rst` pulsed low mid-count at 01:23.4 (asynchronous, between clk edges) → outputs zero immediately. Count restarts only after a new start_stop.
